// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a change amount using the fixed denomination set
//   100, 50, 20, 10, 5, 2, 1 (avail_mask bit 6 = 100 ... bit 0 = 1).
//   The largest denomination that is in stock and fits the remaining
//   amount is picked each round. Each note is presented on disp_* until
//   it is acknowledged.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   chg_valid/ready   request handshake, chg_amount = change to return
//   avail_mask        per-denomination stock present flags
//   disp_valid/note   dispense command, held until disp_ack
//   done / err        one-cycle completion / cannot-complete pulses
//   rem_amount        remaining unpaid amount
//   note_count        notes dispensed for the current/last request (sat. 255)
module change_dispenser (
  input  logic        clk,
  input  logic        rst,
  input  logic        chg_valid,
  input  logic [15:0] chg_amount,
  output logic        chg_ready,
  input  logic [6:0]  avail_mask,
  output logic        disp_valid,
  output logic [6:0]  disp_note,
  input  logic        disp_ack,
  output logic        done,
  output logic        err,
  output logic [15:0] rem_amount,
  output logic [7:0]  note_count
);

  typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, DONE, ERR} state_t;
  state_t state;

  function automatic logic [6:0] denom(input int idx);
    case (idx)
      6:       denom = 7'd100;
      5:       denom = 7'd50;
      4:       denom = 7'd20;
      3:       denom = 7'd10;
      2:       denom = 7'd5;
      1:       denom = 7'd2;
      default: denom = 7'd1;
    endcase
  endfunction

  // Largest stocked denomination not exceeding rem_amount. Because the pick
  // never exceeds rem_amount, the DISPENSE subtraction cannot underflow.
  logic       pick_ok;
  logic [6:0] pick_note;

  always_comb begin
    pick_ok   = 1'b0;
    pick_note = '0;
    for (int i = 6; i >= 0; i--) begin
      if (!pick_ok && avail_mask[i] && ({9'd0, denom(i)} <= rem_amount)) begin
        pick_ok   = 1'b1;
        pick_note = denom(i);
      end
    end
  end

  assign chg_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      disp_valid <= 1'b0;
      disp_note  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      rem_amount <= '0;
      note_count <= '0;
    end else begin
      // done/err are set on entry to DONE/ERR and cleared here next cycle
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (chg_valid) begin
            rem_amount <= chg_amount;
            note_count <= '0;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (rem_amount == 16'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (pick_ok) begin
            disp_note  <= pick_note;
            disp_valid <= 1'b1;
            state      <= DISPENSE;
          end else begin
            err   <= 1'b1;
            state <= ERR;
          end
        end
        DISPENSE: begin
          if (disp_ack) begin
            rem_amount <= rem_amount - {9'd0, disp_note};
            if (note_count != 8'hFF) note_count <= note_count + 8'd1;
            // dropping valid here yields the one-cycle bubble in SELECT
            disp_valid <= 1'b0;
            state      <= SELECT;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst;
  logic        chg_valid;
  logic [15:0] chg_amount;
  logic        chg_ready;
  logic [6:0]  avail_mask;
  logic        disp_valid;
  logic [6:0]  disp_note;
  logic        disp_ack;
  logic        done;
  logic        err;
  logic [15:0] rem_amount;
  logic [7:0]  note_count;

  change_dispenser dut (
    .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_amount(chg_amount),
    .chg_ready(chg_ready), .avail_mask(avail_mask), .disp_valid(disp_valid),
    .disp_note(disp_note), .disp_ack(disp_ack), .done(done), .err(err),
    .rem_amount(rem_amount), .note_count(note_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q[$];

  typedef struct {
    logic [15:0]      amt;
    logic [6:0]       mask;
    int               nn;
    logic [0:7][6:0]  notes;
    logic             exp_err;
    logic [15:0]      exp_rem;
    logic [7:0]       exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge with the expected notes already queued.
  // Drives the request, acks every note, checks the end state. Returns at a negedge.
  task automatic run_req(input string tag, input logic [15:0] amt, input logic [6:0] mask,
                         input logic exp_err, input logic [15:0] exp_rem,
                         input logic [7:0] exp_cnt);
    bit first_disp;
    bit got_end;
    bit prev_ack;
    int cyc;
    first_disp = (exp_q.size() != 0);
    chg_amount = amt;
    avail_mask = mask;
    chg_valid  = 1'b1;
    chk({tag, "_ready"}, chg_ready, 1'b1);
    @(negedge clk);
    chg_valid = 1'b0;
    chk({tag, "_loaded"}, rem_amount, amt);
    chk({tag, "_cnt0"}, note_count, 0);
    chk({tag, "_sel_novalid"}, disp_valid, 1'b0);
    got_end  = 0;
    prev_ack = 0;
    cyc      = 0;
    while (!got_end && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      disp_ack = 1'b0;
      if (cyc == 1) chk({tag, "_first_valid"}, disp_valid, first_disp);
      if (prev_ack) chk({tag, "_bubble"}, disp_valid, 1'b0);
      prev_ack = 0;
      if (done || err) begin
        got_end = 1;
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_done"}, done, !exp_err);
        chk({tag, "_rem"}, rem_amount, exp_rem);
        chk({tag, "_cnt"}, note_count, exp_cnt);
        chk({tag, "_leftover_notes"}, exp_q.size(), 0);
      end else if (disp_valid) begin
        if (exp_q.size() == 0) chk({tag, "_extra_note"}, disp_note, 0);
        else chk({tag, "_note"}, disp_note, exp_q.pop_front());
        disp_ack = 1'b1;
        prev_ack = 1;
      end
    end
    if (!got_end) chk({tag, "_timeout"}, 1, 0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_pulse_end"}, {done, err}, 2'b00);
    chk({tag, "_idle_ready"}, chg_ready, 1'b1);
    chk({tag, "_hold_cnt"}, note_count, exp_cnt);
  endtask

  initial begin
    bit hit;
    int acks;
    int cyc;

    vecs[0] = '{16'd186, 7'h7F, 6, {7'd100, 7'd50, 7'd20, 7'd10, 7'd5, 7'd1, 14'd0}, 1'b0, 16'd0, 8'd6};
    vecs[1] = '{16'd0,   7'h7F, 0, 56'd0, 1'b0, 16'd0, 8'd0};
    vecs[2] = '{16'd150, 7'b0111111, 3, {7'd50, 7'd50, 7'd50, 35'd0}, 1'b0, 16'd0, 8'd3};
    vecs[3] = '{16'd175, 7'b1100000, 2, {7'd100, 7'd50, 42'd0}, 1'b1, 16'd25, 8'd2};
    vecs[4] = '{16'd7,   7'h7F, 2, {7'd5, 7'd2, 42'd0}, 1'b0, 16'd0, 8'd2};
    vecs[5] = '{16'd3,   7'b0000010, 1, {7'd2, 49'd0}, 1'b1, 16'd1, 8'd1};
    vecs[6] = '{16'd1,   7'h00, 0, 56'd0, 1'b1, 16'd1, 8'd0};
    vecs[7] = '{16'd300, 7'b1000000, 3, {7'd100, 7'd100, 7'd100, 35'd0}, 1'b0, 16'd0, 8'd3};

    rst = 1'b1; chg_valid = 1'b0; chg_amount = '0; avail_mask = '0; disp_ack = 1'b0;
    #1;
    chk("rst_ready", chg_ready, 1'b1);
    chk("rst_outs", {disp_valid, disp_note, done, err}, 0);
    chk("rst_rem", rem_amount, 0);
    chk("rst_cnt", note_count, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].nn; k++) exp_q.push_back(vecs[v].notes[k]);
      run_req($sformatf("vec%0d", v), vecs[v].amt, vecs[v].mask,
              vecs[v].exp_err, vecs[v].exp_rem, vecs[v].exp_cnt);
    end

    // note_count saturation: 260 one-unit coins
    for (int k = 0; k < 260; k++) exp_q.push_back(7'd1);
    run_req("sat", 16'd260, 7'h01, 1'b0, 16'd0, 8'd255);

    // ack held off: command must stay stable, busy request ignored
    chg_amount = 16'd50; avail_mask = 7'h7F; chg_valid = 1'b1;
    @(negedge clk);
    chg_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid", disp_valid, 1'b1);
      chk("hold_note", disp_note, 7'd50);
      if (c == 3) begin
        chk("hold_busy_ready", chg_ready, 1'b0);
        chg_amount = 16'd99; chg_valid = 1'b1;
      end else begin
        chg_valid = 1'b0;
      end
    end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    @(negedge clk);
    chk("hold_done", done, 1'b1);
    chk("hold_rem", rem_amount, 0);
    chk("hold_cnt", note_count, 1);
    @(negedge clk);

    // reset while the third note of 186 is being presented
    chg_amount = 16'd186; avail_mask = 7'h7F; chg_valid = 1'b1;
    @(negedge clk);
    chg_valid = 1'b0;
    hit = 0; acks = 0; cyc = 0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      cyc++;
      disp_ack = 1'b0;
      if (disp_valid && acks == 2) hit = 1;
      else if (disp_valid) begin disp_ack = 1'b1; acks++; end
    end
    chk("mid_reached", hit, 1'b1);
    chk("mid_note", disp_note, 7'd20);
    chk("mid_rem", rem_amount, 16'd36);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", disp_valid, 1'b0);
    chk("mid_rst_note", disp_note, 0);
    chk("mid_rst_rem", rem_amount, 0);
    chk("mid_rst_cnt", note_count, 0);
    chk("mid_rst_ready", chg_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_nopulse", {done, err}, 2'b00);
    end
    rst = 1'b0;
    exp_q.push_back(7'd5);
    exp_q.push_back(7'd2);
    run_req("post_rst", 16'd7, 7'h7F, 1'b0, 16'd0, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
